bg_rom_arbiter: RTL and testbench

- Shares the single read port of the background/portrait ROM between two requesters: the display fetch path (disp, high priority) and an auxiliary reader (aux, low priority, e.g. menu/collision lookup).
- Drives the ROM's address and image-select inputs and steers the returned pixel index to the requester that issued the read.
- Fully pipelined: one read per cycle, fixed 2-cycle latency. An anti-starvation counter guarantees aux forward progress.

---
 rtl/bg_rom_arbiter.sv | 142 ++++++++++++++
 tb/tb_bg_rom_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bg_rom_arbiter.sv
// Background/portrait ROM read-port arbiter.
// Two requesters share one ROM read port: disp has priority and aux has anti-starvation.
// The port accepts one read per cycle with a fixed 2-cycle response latency.
// An address range check forces out-of-range reads to return zero and sets a sticky error flag.
module bg_rom_arbiter #(
   parameter int unsigned MAX_DEFER = 4,
   parameter int unsigned BG_DEPTH  = 153600,
   parameter int unsigned P_DEPTH   = 76800
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        disp_req,
   input  logic [18:0] disp_addr,
   input  logic [1:0]  disp_sel,
   output logic        disp_gnt,
   output logic        disp_valid,
   output logic [4:0]  disp_data,
   input  logic        aux_req,
   input  logic [18:0] aux_addr,
   input  logic [1:0]  aux_sel,
   output logic        aux_gnt,
   output logic        aux_valid,
   output logic [4:0]  aux_data,
   output logic [18:0] rom_addr,
   output logic [1:0]  rom_sel,
   input  logic [4:0]  rom_data,
   input  logic        err_clr,
   output logic        addr_err
);

   typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

   state_t      state;
   logic [3:0]  defer_cnt;
   logic [3:0]  defer_nxt;
   logic        force_nxt;

   logic        g_valid;
   logic        g_owner;   // 1 = aux
   logic [18:0] g_addr;
   logic [1:0]  g_sel;
   logic        g_in_range;
   logic        g_viol;
   logic        g_zero;

   // Two-stage response tag: valid, owner, and force-zero data
   logic        t1_valid, t1_owner, t1_zero;
   logic        t2_valid, t2_owner, t2_zero;

   // Grant decision: FORCE hands the slot to aux; otherwise disp has priority
   always_comb begin
      disp_gnt = 1'b0;
      aux_gnt  = 1'b0;
      if (Reset_n) begin
         if (state == ST_FORCE)
            aux_gnt = aux_req;
         else if (disp_req)
            disp_gnt = 1'b1;
         else if (aux_req)
            aux_gnt = 1'b1;
      end
   end

   // Select the granted request and check its address against the image depth
   always_comb begin
      g_valid = disp_gnt | aux_gnt;
      g_owner = aux_gnt;
      g_addr  = aux_gnt ? aux_addr : disp_addr;
      g_sel   = aux_gnt ? aux_sel  : disp_sel;
      case (g_sel)
         2'd0:    g_in_range = 1'b1;
         2'd1:    g_in_range = 32'(g_addr) < BG_DEPTH;
         default: g_in_range = 32'(g_addr) < P_DEPTH;
      endcase
      g_viol = g_valid & ~g_in_range;
      g_zero = (g_sel == 2'd0) | ~g_in_range;
   end

   // Defer counter next value and the decision to force an aux slot
   always_comb begin
      if (!aux_req || aux_gnt)
         defer_nxt = '0;
      else if (defer_cnt != 4'hF)
         defer_nxt = defer_cnt + 4'd1;
      else
         defer_nxt = defer_cnt;
      force_nxt = aux_req && !aux_gnt && (32'(defer_nxt) >= MAX_DEFER);
   end

   // Arbitration FSM and the anti-starvation counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_NORMAL;
         defer_cnt <= '0;
      end else begin
         defer_cnt <= defer_nxt;
         state     <= force_nxt ? ST_FORCE : ST_NORMAL;
      end
   end

   // ROM address/select registers and the response tag pipeline
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_addr <= '0;
         rom_sel  <= '0;
         t1_valid <= 1'b0;
         t1_owner <= 1'b0;
         t1_zero  <= 1'b0;
         t2_valid <= 1'b0;
         t2_owner <= 1'b0;
         t2_zero  <= 1'b0;
      end else begin
         rom_addr <= g_addr;
         rom_sel  <= (g_valid && g_in_range) ? g_sel : 2'd0;
         t1_valid <= g_valid;
         t1_owner <= g_owner;
         t1_zero  <= g_zero;
         t2_valid <= t1_valid;
         t2_owner <= t1_owner;
         t2_zero  <= t1_zero;
      end
   end

   // Sticky range-error flag; a new violation wins over a simultaneous clear
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         addr_err <= 1'b0;
      else if (g_viol)
         addr_err <= 1'b1;
      else if (err_clr)
         addr_err <= 1'b0;
   end

   // Steer returned data to the owner; the other requester sees zero
   always_comb begin
      disp_valid = t2_valid & ~t2_owner;
      aux_valid  = t2_valid &  t2_owner;
      disp_data  = (disp_valid && !t2_zero) ? rom_data : '0;
      aux_data   = (aux_valid  && !t2_zero) ? rom_data : '0;
   end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed self-checking bench for bg_rom_arbiter with a registered ROM model.
module tb_bg_rom_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        disp_req, aux_req, err_clr;
   logic [18:0] disp_addr, aux_addr;
   logic [1:0]  disp_sel, aux_sel;
   logic        disp_gnt, disp_valid, aux_gnt, aux_valid, addr_err;
   logic [4:0]  disp_data, aux_data, rom_data;
   logic [18:0] rom_addr;
   logic [1:0]  rom_sel;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   bg_rom_arbiter #(.MAX_DEFER(4), .BG_DEPTH(153600), .P_DEPTH(76800)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_sel(disp_sel),
      .disp_gnt(disp_gnt), .disp_valid(disp_valid), .disp_data(disp_data),
      .aux_req(aux_req), .aux_addr(aux_addr), .aux_sel(aux_sel),
      .aux_gnt(aux_gnt), .aux_valid(aux_valid), .aux_data(aux_data),
      .rom_addr(rom_addr), .rom_sel(rom_sel), .rom_data(rom_data),
      .err_clr(err_clr), .addr_err(addr_err)
   );

   always #5 Clk = ~Clk;

   // ROM contents: sel 0 reads as zero; each image has a distinct pattern
   function automatic logic [4:0] rom_fn(input logic [1:0] sel, input logic [18:0] addr);
      case (sel)
         2'd1:    rom_fn = addr[4:0] ^ 5'h1F;   // mem_bg[5] = 0x1A
         2'd2:    rom_fn = addr[4:0] + 5'd3;
         2'd3:    rom_fn = addr[4:0] ^ 5'h0A;
         default: rom_fn = 5'd0;
      endcase
   endfunction

   always @(posedge Clk) rom_data <= rom_fn(rom_sel, rom_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge Clk);
      #1;
   endtask

   task automatic set_req(input logic dr, input logic [18:0] da, input logic [1:0] ds,
                          input logic ar, input logic [18:0] aa, input logic [1:0] as_);
      disp_req = dr; disp_addr = da; disp_sel = ds;
      aux_req  = ar; aux_addr  = aa; aux_sel  = as_;
   endtask

   task automatic drain;
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      repeat (3) step();
   endtask

   int unsigned valid_seen;

   initial begin
      Reset_n = 1'b0;
      err_clr = 1'b0;
      rom_data = '0;
      set_req(1'b1, 19'd1, 2'd1, 1'b1, 19'd2, 2'd2);

      // Reset: both requesting, nothing granted or returned
      repeat (2) step();
      @(negedge Clk);
      check("rst_disp_gnt",   32'(disp_gnt),   32'd0);
      check("rst_aux_gnt",    32'(aux_gnt),    32'd0);
      check("rst_disp_valid", 32'(disp_valid), 32'd0);
      check("rst_aux_valid",  32'(aux_valid),  32'd0);
      check("rst_rom_sel",    32'(rom_sel),    32'd0);
      check("rst_addr_err",   32'(addr_err),   32'd0);
      Reset_n = 1'b1;
      #1;
      check("rel_disp_gnt", 32'(disp_gnt), 32'd1);
      check("rel_aux_gnt",  32'(aux_gnt),  32'd0);
      step();
      drain();

      // Latency: one disp read of bg[5]
      set_req(1'b1, 19'd5, 2'd1, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("lat_gnt", 32'(disp_gnt), 32'd1);
      step();
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("lat_n1_valid", 32'(disp_valid), 32'd0);
      step();
      @(negedge Clk);
      check("lat_n2_valid", 32'(disp_valid), 32'd1);
      check("lat_n2_data",  32'(disp_data),  32'h1A);
      check("lat_n2_avalid", 32'(aux_valid), 32'd0);
      check("lat_n2_adata",  32'(aux_data),  32'd0);
      step();
      @(negedge Clk);
      check("lat_n3_valid", 32'(disp_valid), 32'd0);
      drain();

      // Starvation: both held, aux forced every 5th cycle
      set_req(1'b1, 19'd7, 2'd1, 1'b1, 19'd8, 2'd2);
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check($sformatf("starve_aux_%0d", i),  32'(aux_gnt),  32'((i % 5) == 4));
         check($sformatf("starve_disp_%0d", i), 32'(disp_gnt), 32'((i % 5) != 4));
         step();
      end
      drain();

      // Pipelining: alternating owners, back-to-back responses in order
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin
            if ((i % 2) == 0) set_req(1'b1, 19'(10 + i), 2'd1, 1'b0, '0, 2'd0);
            else              set_req(1'b0, '0, 2'd0, 1'b1, 19'(20 + i), 2'd2);
         end else begin
            set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
         end
         @(negedge Clk);
         if (i >= 2) begin
            int j;
            j = i - 2;
            if ((j % 2) == 0) begin
               check($sformatf("pipe_dv_%0d", j), 32'(disp_valid), 32'd1);
               check($sformatf("pipe_av_%0d", j), 32'(aux_valid),  32'd0);
               check($sformatf("pipe_dd_%0d", j), 32'(disp_data),
                     32'(rom_fn(2'd1, 19'(10 + j))));
            end else begin
               check($sformatf("pipe_dv_%0d", j), 32'(disp_valid), 32'd0);
               check($sformatf("pipe_av_%0d", j), 32'(aux_valid),  32'd1);
               check($sformatf("pipe_ad_%0d", j), 32'(aux_data),
                     32'(rom_fn(2'd2, 19'(20 + j))));
            end
         end
         step();
      end
      @(negedge Clk);
      check("pipe_end_dv", 32'(disp_valid), 32'd0);
      check("pipe_end_av", 32'(aux_valid),  32'd0);
      drain();

      // Range error: aux p1 read at P_DEPTH
      set_req(1'b0, '0, 2'd0, 1'b1, 19'd76800, 2'd2);
      @(negedge Clk);
      check("rng_gnt", 32'(aux_gnt), 32'd1);
      step();
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("rng_rom_sel", 32'(rom_sel),  32'd0);
      check("rng_err",     32'(addr_err), 32'd1);
      step();
      @(negedge Clk);
      check("rng_avalid", 32'(aux_valid), 32'd1);
      check("rng_adata",  32'(aux_data),  32'd0);
      check("rng_err_held", 32'(addr_err), 32'd1);
      step();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      @(negedge Clk);
      check("clr_err", 32'(addr_err), 32'd0);

      // Last legal p1 address: no error, select passes through
      set_req(1'b0, '0, 2'd0, 1'b1, 19'd76799, 2'd2);
      step();
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("edge_rom_sel", 32'(rom_sel),  32'd2);
      check("edge_err",     32'(addr_err), 32'd0);
      step();
      @(negedge Clk);
      check("edge_adata", 32'(aux_data), 32'(rom_fn(2'd2, 19'd76799)));

      // Violation coincident with err_clr: set wins
      set_req(1'b1, 19'd153600, 2'd1, 1'b0, '0, 2'd0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("setwins_err", 32'(addr_err), 32'd1);
      drain();
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;

      // Reset mid-flight: the granted read never returns
      set_req(1'b1, 19'd5, 2'd1, 1'b0, '0, 2'd0);
      @(negedge Clk);
      check("mid_gnt", 32'(disp_gnt), 32'd1);
      step();
      set_req(1'b0, '0, 2'd0, 1'b0, '0, 2'd0);
      Reset_n = 1'b0;
      valid_seen = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (disp_valid || aux_valid) valid_seen++;
         if (i == 1) Reset_n = 1'b1;
      end
      check("mid_no_valid", 32'(valid_seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
